// File: rtl/stack_arb_pkg.sv
// rtl/stack_arb_pkg.sv - shared FSM encodings and op codes for the stack arbiter
package stack_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PUSH = 3'd1,
        ST_POP  = 3'd2,
        ST_RESP = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin selector keyed on the last granted index
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner,
    output logic valid
);

    // On contention the requester that was not granted last wins.
    assign winner = (req0 && req1) ? ~last : req1;
    assign valid  = req0 | req1;

endmodule

// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - two-requester round-robin front end to a push/pop stack
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int WORD_BITS  = 4,
    parameter int DEPTH_BITS = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 op0,
    input  logic                 op1,
    input  logic [WORD_BITS-1:0] wdata0,
    input  logic [WORD_BITS-1:0] wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 err0,
    output logic                 err1,
    output logic [WORD_BITS-1:0] rdata,
    output logic                 s_push,
    output logic                 s_pop,
    output logic [WORD_BITS-1:0] s_wdata,
    input  logic [WORD_BITS-1:0] s_rdata,
    output logic                 full,
    output logic                 empty
);

    localparam logic [DEPTH_BITS:0] DEPTH_CNT = (DEPTH_BITS+1)'(2**DEPTH_BITS);
    localparam logic [DEPTH_BITS:0] CNT_ONE   = (DEPTH_BITS+1)'(1);

    state_t                state_q, state_d;
    logic [DEPTH_BITS:0]   count_q, count_d;
    logic                  last_q, last_d;
    logic                  idx_q, idx_d;
    logic [WORD_BITS-1:0]  wdata_q, wdata_d;
    logic [WORD_BITS-1:0]  rdata_q, rdata_d;

    logic                  rr_winner, rr_valid;
    logic                  sel_op;
    logic [WORD_BITS-1:0]  sel_wdata;
    logic                  gnt_pulse, err_pulse;

    rr_arb2 u_rr_arb2 (
        .req0   (req0),
        .req1   (req1),
        .last   (last_q),
        .winner (rr_winner),
        .valid  (rr_valid)
    );

    assign sel_op    = rr_winner ? op1 : op0;
    assign sel_wdata = rr_winner ? wdata1 : wdata0;
    assign full      = (count_q == DEPTH_CNT);
    assign empty     = (count_q == '0);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        last_d    = last_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        gnt_pulse = 1'b0;
        err_pulse = 1'b0;
        s_push    = 1'b0;
        s_pop     = 1'b0;
        rdata     = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (rr_valid) begin
                    idx_d   = rr_winner;
                    wdata_d = sel_wdata;
                    // The chosen state doubles as the latched operation.
                    if (sel_op == OP_PUSH) state_d = full  ? ST_ERR : ST_PUSH;
                    else                   state_d = empty ? ST_ERR : ST_POP;
                end
            end
            ST_PUSH: begin
                s_push    = 1'b1;
                gnt_pulse = 1'b1;
                count_d   = count_q + CNT_ONE;
                last_d    = idx_q;
                state_d   = ST_IDLE;
            end
            ST_POP: begin
                s_pop   = 1'b1;
                count_d = count_q - CNT_ONE;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                // Forward the stack word alongside gnt, then hold it.
                gnt_pulse = 1'b1;
                rdata     = s_rdata;
                rdata_d   = s_rdata;
                last_d    = idx_q;
                state_d   = ST_IDLE;
            end
            ST_ERR: begin
                gnt_pulse = 1'b1;
                err_pulse = 1'b1;
                last_d    = idx_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign gnt0    = gnt_pulse & ~idx_q;
    assign gnt1    = gnt_pulse &  idx_q;
    assign err0    = err_pulse & ~idx_q;
    assign err1    = err_pulse &  idx_q;
    assign s_wdata = wdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            last_q  <= 1'b1;
            idx_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// tb/tb_stack_arbiter.sv - directed and randomized self-checking bench for stack_arbiter
module tb_stack_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
    logic [3:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, err0, err1, s_push, s_pop, full, empty;
    logic [3:0] rdata, s_wdata;
    logic [3:0] s_rdata = '0;

    stack_arbiter #(.WORD_BITS(4), .DEPTH_BITS(2)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .err0(err0), .err1(err1),
        .rdata(rdata), .s_push(s_push), .s_pop(s_pop),
        .s_wdata(s_wdata), .s_rdata(s_rdata),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Stack memory seen by the arbiter: pop data appears the cycle after s_pop.
    logic [3:0] mem[$];
    int n_push = 0, n_pop = 0, n_clash = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem.delete();
        end else begin
            if (s_push) begin
                mem.push_back(s_wdata);
                n_push <= n_push + 1;
            end
            if (s_pop) begin
                n_pop <= n_pop + 1;
                if (mem.size() > 0) s_rdata <= mem.pop_back();
            end
            if ((gnt0 && gnt1) || (s_push && s_pop)) n_clash <= n_clash + 1;
        end
    end

    // Transaction-level reference: occupancy list and last-granted index.
    logic [3:0] ref_stk[$];
    int         ref_last;
    int         n_total = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        req0 = 0; req1 = 0; op0 = 0; op1 = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        ref_stk.delete();
        ref_last = 1;
        @(negedge clk);
    endtask

    // Apply one request pattern at a negedge in IDLE and check the resulting grant.
    task automatic txn(input string tag, input bit r0, input bit r1, input bit o0, input bit o1,
                       input logic [3:0] w0, input logic [3:0] w1);
        int   w, lat, exp_lat, p0, q0;
        bit   op, legal;
        logic [3:0] d, exp_r;
        w     = (r0 && r1) ? 1 - ref_last : (r1 ? 1 : 0);
        op    = w ? o1 : o0;
        d     = w ? w1 : w0;
        legal = op ? (ref_stk.size() < 4) : (ref_stk.size() > 0);
        exp_lat = (legal && !op) ? 2 : 1;
        exp_r = (legal && !op) ? ref_stk[ref_stk.size()-1] : 4'h0;
        p0 = n_push; q0 = n_pop;
        req0 = r0; req1 = r1; op0 = o0; op1 = o1; wdata0 = w0; wdata1 = w1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(gnt0 || gnt1) && lat < 8);
        chk({tag, "_gnt_seen"}, {31'd0, gnt0 | gnt1}, 32'd1);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_winner"}, {30'd0, gnt1, gnt0}, (w ? 32'd2 : 32'd1));
        chk({tag, "_err"}, {30'd0, err1, err0}, legal ? 32'd0 : (w ? 32'd2 : 32'd1));
        if (legal && op)  chk({tag, "_s_wdata"}, {27'd0, s_push, s_wdata}, {27'd0, 1'b1, d});
        if (legal && !op) chk({tag, "_rdata"}, rdata, exp_r);
        req0 = 0; req1 = 0;
        @(negedge clk);
        chk({tag, "_push_pulses"}, n_push - p0, (legal && op) ? 1 : 0);
        chk({tag, "_pop_pulses"}, n_pop - q0, (legal && !op) ? 1 : 0);
        if (legal && !op) chk({tag, "_rdata_hold"}, rdata, exp_r);
        ref_last = w;
        if (legal && op) ref_stk.push_back(d);
        if (legal && !op) void'(ref_stk.pop_back());
        chk({tag, "_flags"}, {30'd0, full, empty},
            {30'd0, ref_stk.size() == 4, ref_stk.size() == 0});
    endtask

    initial begin
        int who, lat;
        bit r0, r1;
        ref_last = 1;
        // Reset values while rst is held low.
        #12;
        chk("rst_outs", {26'd0, gnt0, gnt1, err0, err1, s_push, s_pop},  32'd0);
        chk("rst_data", {24'd0, rdata, s_wdata}, 32'd0);
        chk("rst_flags", {30'd0, full, empty}, 32'd1);
        do_reset();

        txn("push_a", 1, 0, 1, 0, 4'hA, 4'h0);

        do_reset();
        txn("lifo_p1", 1, 0, 1, 0, 4'h1, 4'h0);
        txn("lifo_p2", 1, 0, 1, 0, 4'h2, 4'h0);
        txn("lifo_q1", 0, 1, 0, 0, 4'h0, 4'h0);
        txn("lifo_q2", 0, 1, 0, 0, 4'h0, 4'h0);

        do_reset();
        for (int i = 0; i < 5; i++) txn("fill", 1, 0, 1, 0, 4'(i + 3), 4'h0);

        do_reset();
        txn("pop_empty", 1, 0, 0, 0, 4'h0, 4'h0);

        // Both requesters held continuously: grants must alternate starting with req0.
        do_reset();
        req0 = 1; req1 = 1; op0 = 1; op1 = 1; wdata0 = 4'h3; wdata1 = 4'h5;
        for (int g = 0; g < 6; g++) begin
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!(gnt0 || gnt1) && lat < 8);
            who = gnt1 ? 1 : 0;
            chk("rr_alt_winner", {30'd0, gnt1, gnt0}, (ref_last == 0) ? 32'd2 : 32'd1);
            chk("rr_alt_err", {31'd0, err0 | err1}, (ref_stk.size() < 4) ? 32'd0 : 32'd1);
            if (ref_stk.size() < 4) ref_stk.push_back(who ? 4'h5 : 4'h3);
            ref_last = 1 - ref_last;
        end
        req0 = 0; req1 = 0;
        @(negedge clk);

        // Reset while the pop is in flight.
        do_reset();
        txn("pre_pop", 1, 0, 1, 0, 4'h7, 4'h0);
        req1 = 1; op1 = 0;
        @(negedge clk);
        chk("mid_pop_state", {31'd0, s_pop}, 32'd1);
        rst = 1'b0;
        req1 = 0;
        #1;
        chk("abort_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("abort_flags", {30'd0, full, empty}, 32'd1);
        @(negedge clk);
        chk("abort_no_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        rst = 1'b1;
        ref_stk.delete();
        ref_last = 1;
        txn("post_abort", 0, 1, 0, 1, 4'h0, 4'h9);

        // Randomized traffic against the reference.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            txn("rand", r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                4'($urandom), 4'($urandom));
        end

        chk("no_clash", n_clash, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
